pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 27 ++
 rtl/ras_stack.sv | 76 +++++++
 rtl/pc_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared program-counter definitions: default sizing constants and the
// next-PC source encoding used by pc_unit.
package pc_pkg;

  localparam int PC_WIDTH = 32;
  localparam int PC_STEP  = 4;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    RETURN = 2'd3
  } pc_src_e;

  // Return wins over everything; a return with nothing to pop falls back to
  // the sequential address rather than to a jump or branch.
  function automatic pc_src_e select_src(input logic ret,
                                         input logic stack_empty,
                                         input logic jmp,
                                         input logic br_taken);
    if (ret)      return stack_empty ? SEQ : RETURN;
    if (jmp)      return JUMP;
    if (br_taken) return BRANCH;
    return SEQ;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty is ignored; both raise a sticky overflow flag.
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] entry_reg [DEPTH];
  logic [PTR_W-1:0] top_ptr_reg, top_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic             do_push;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_CNT);
  assign ovf   = ovf_reg;
  assign top   = entry_reg[top_ptr_reg];

  // A simultaneous push and pop resolves to the pop alone.
  assign do_push = push & ~pop;

  always_comb begin
    top_ptr_next = top_ptr_reg;
    count_next   = count_reg;
    ovf_next     = ovf_reg;
    if (pop) begin
      if (empty) begin
        ovf_next = 1'b1;
      end else begin
        top_ptr_next = top_ptr_reg - PTR_W'(1);
        count_next   = count_reg - CNT_W'(1);
      end
    end else if (do_push) begin
      top_ptr_next = top_ptr_reg + PTR_W'(1);
      if (full) begin
        ovf_next = 1'b1;
      end else begin
        count_next = count_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      top_ptr_reg <= '0;
      count_reg   <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      top_ptr_reg <= top_ptr_next;
      count_reg   <= count_next;
      ovf_reg     <= ovf_next;
    end
  end

  // Entry storage carries no reset; contents are only read while non-empty.
  always_ff @(negedge clock) begin
    if (do_push) begin
      entry_reg[top_ptr_next] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection (return > jump > branch > sequential)
// with an optional return-address stack built when PC_UNIT_RAS_EN is defined.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter int               STEP         = PC_STEP,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             link,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf
);

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] ras_top;
  logic             ret_eff;
  pc_src_e          src;

  assign pc_plus = pc_reg + WIDTH'(STEP);

`ifdef PC_UNIT_RAS_EN
  logic ras_push;
  logic ras_pop;

  assign ret_eff  = ret;
  assign ras_pop  = ret & ~stall;
  assign ras_push = jmp & link & ~ret & ~stall;

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf)
  );
`else
  logic unused_inputs;

  assign ret_eff       = 1'b0;
  assign ras_top       = '0;
  assign ras_empty     = 1'b1;
  assign ras_full      = 1'b0;
  assign ras_ovf       = 1'b0;
  assign unused_inputs = &{1'b0, link, ret};
`endif

  assign src = select_src(ret_eff, ras_empty, jmp, br_taken);

  always_comb begin
    pc_next = pc_plus;
    case (src)
      RETURN:  pc_next = ras_top;
      JUMP:    pc_next = jmp_target;
      BRANCH:  pc_next = br_target;
      default: pc_next = pc_plus;
    endcase
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg <= RESET_VECTOR;
    end else if (!stall) begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule
